// File: rtl/difftest_delayed_update_queue_if.sv
// +----------------------------------------------------------------------------+
// | Module   : difftest_delayed_update_queue_if                                |
// | Purpose  : Bundles the writeback inputs, drain handshake, emitted event    |
// |            fields and status of the delayed-update queue.                  |
// | Ports    : master = event source / sink side (drives in*, drain_en,        |
// |            io_coreid); slave = the queue itself.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface difftest_delayed_update_queue_if #(
  parameter int DEPTH = 8
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  // Writeback events; in0 is the older of the pair.
  logic               in0_valid;
  logic [4:0]         in0_address;
  logic [63:0]        in0_data;
  logic               in0_nack;
  logic               in1_valid;
  logic [4:0]         in1_address;
  logic [63:0]        in1_data;
  logic               in1_nack;
  logic [7:0]         io_coreid;
  logic               drain_en;

  // Emitted event and status.
  logic               out_valid;
  logic [4:0]         out_address;
  logic [63:0]        out_data;
  logic               out_nack;
  logic [7:0]         out_coreid;
  logic [7:0]         out_index;
  logic [c_CNT_W-1:0] count;
  logic               overflow;
  logic [15:0]        drop_cnt;

  modport master (
    output in0_valid, in0_address, in0_data, in0_nack,
    output in1_valid, in1_address, in1_data, in1_nack,
    output io_coreid, drain_en,
    input  out_valid, out_address, out_data, out_nack, out_coreid, out_index,
    input  count, overflow, drop_cnt
  );

  modport slave (
    input  in0_valid, in0_address, in0_data, in0_nack,
    input  in1_valid, in1_address, in1_data, in1_nack,
    input  io_coreid, drain_en,
    output out_valid, out_address, out_data, out_nack, out_coreid, out_index,
    output count, overflow, drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/difftest_delayed_update_queue.sv
// +----------------------------------------------------------------------------+
// | Module   : difftest_delayed_update_queue                                   |
// | Purpose  : Buffers up to two delayed int-writeback events per cycle and    |
// |            hands them one per cycle, in order, to the difftest sink.       |
// |            Writes to x0 are ignored; events arriving while full are        |
// |            dropped and counted.                                            |
// | Ports    : clock  - sole clock, rising edge                                |
// |            reset  - asynchronous, active-high                              |
// |            bus    - slave modport of difftest_delayed_update_queue_if      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module difftest_delayed_update_queue #(
  parameter int DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  difftest_delayed_update_queue_if.slave bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  // Storage (no reset needed: pointers/count define what is live).
  logic [4:0]         r_mem_addr [DEPTH];
  logic [63:0]        r_mem_data [DEPTH];
  logic               r_mem_nack [DEPTH];

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic [15:0]        r_drop_cnt;
  logic [7:0]         r_emit_cnt;

  logic               r_out_valid;
  logic [4:0]         r_out_address;
  logic [63:0]        r_out_data;
  logic               r_out_nack;
  logic [7:0]         r_out_coreid;
  logic [7:0]         r_out_index;

  logic               w_elig0;
  logic               w_elig1;
  logic [c_CNT_W-1:0] w_free;
  logic               w_acc0;
  logic               w_acc1;
  logic [c_PTR_W-1:0] w_slot1;
  logic [1:0]         w_n_enq;
  logic [1:0]         w_n_drop;
  logic               w_deq;
  logic [16:0]        w_drop_sum;

  assign w_elig0 = bus.in0_valid && (bus.in0_address != 5'd0);
  assign w_elig1 = bus.in1_valid && (bus.in1_address != 5'd0);

  // Space comes only from the registered count, so a dequeue in this cycle
  // never makes room for an enqueue in the same cycle.
  assign w_free  = c_DEPTH - r_count;
  assign w_acc0  = w_elig0 && (w_free != '0);
  // in1 needs a second free slot only when in0 already took one.
  assign w_acc1  = w_elig1 && (w_acc0 ? (w_free >= c_CNT_W'(2)) : (w_free != '0));

  // in1 lands behind in0 when both are accepted, otherwise at the write pointer.
  assign w_slot1 = w_acc0 ? (r_wr_ptr + c_PTR_W'(1)) : r_wr_ptr;

  assign w_n_enq    = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_n_drop   = {1'b0, w_elig0 && !w_acc0} + {1'b0, w_elig1 && !w_acc1};
  assign w_deq      = bus.drain_en && (r_count != '0);
  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_n_drop);

  always_ff @(posedge clock) begin
    if (w_acc0) begin
      r_mem_addr[r_wr_ptr] <= bus.in0_address;
      r_mem_data[r_wr_ptr] <= bus.in0_data;
      r_mem_nack[r_wr_ptr] <= bus.in0_nack;
    end
    if (w_acc1) begin
      r_mem_addr[w_slot1] <= bus.in1_address;
      r_mem_data[w_slot1] <= bus.in1_data;
      r_mem_nack[w_slot1] <= bus.in1_nack;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_drop_cnt    <= 16'd0;
      r_emit_cnt    <= 8'd0;
      r_out_valid   <= 1'b0;
      r_out_address <= 5'd0;
      r_out_data    <= 64'd0;
      r_out_nack    <= 1'b0;
      r_out_coreid  <= 8'd0;
      r_out_index   <= 8'd0;
    end else begin
      // Pointer widths equal log2(DEPTH), so wrap is the natural overflow.
      r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_n_enq);
      r_count  <= r_count + c_CNT_W'(w_n_enq) - c_CNT_W'(w_deq);

      if (w_n_drop != 2'd0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end

      r_out_valid <= w_deq;
      if (w_deq) begin
        r_rd_ptr      <= r_rd_ptr + c_PTR_W'(1);
        r_out_address <= r_mem_addr[r_rd_ptr];
        r_out_data    <= r_mem_data[r_rd_ptr];
        r_out_nack    <= r_mem_nack[r_rd_ptr];
        r_out_coreid  <= bus.io_coreid;
        r_out_index   <= r_emit_cnt;
        r_emit_cnt    <= r_emit_cnt + 8'd1;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_address = r_out_address;
  assign bus.out_data    = r_out_data;
  assign bus.out_nack    = r_out_nack;
  assign bus.out_coreid  = r_out_coreid;
  assign bus.out_index   = r_out_index;
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.drop_cnt    = r_drop_cnt;

endmodule

`default_nettype wire
